// File: rtl/tdc_meas_ctrl.sv
// TDC measurement sequencer: clear, coarse count start->hit,
// settle, popcount taps, report one result per sample.
module tdc_meas_ctrl #(
  parameter int NUM_STAGES    = 10,
  parameter int COARSE_W      = 16,
  parameter int SETTLE_CYCLES = 2,
  parameter int CLR_CYCLES    = 10,
  parameter int TIMEOUT       = 1000,
  parameter int FINE_W        = $clog2(NUM_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_samples,
  input  logic                  start_pulse,
  input  logic                  hit,
  output logic                  tdc_clr,
  input  logic [NUM_STAGES-1:0] tdc_stages,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [COARSE_W-1:0]   res_coarse,
  output logic [FINE_W-1:0]     res_fine,
  output logic                  res_timeout,
  output logic                  res_last,
  output logic                  busy
);

  localparam int CLR_W = $clog2(CLR_CYCLES + 1);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT,
    S_RUN,
    S_SETTLE,
    S_REPORT
  } state_t;

  state_t              state;
  logic [3:0]          remaining;
  logic [CLR_W-1:0]    clr_cnt;
  logic [SET_W-1:0]    set_cnt;
  logic [COARSE_W-1:0] coarse;
  logic [COARSE_W-1:0] coarse_inc;
  logic                at_limit;

  function automatic logic [FINE_W-1:0] popcount(
    input logic [NUM_STAGES-1:0] v
  );
    logic [FINE_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_STAGES; i++)
      n = n + FINE_W'(v[i]);
    return n;
  endfunction

  assign coarse_inc = coarse + COARSE_W'(1);
  assign at_limit   = (coarse_inc == COARSE_W'(TIMEOUT));

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign tdc_clr   = reset | (state == S_CLEAR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      remaining   <= '0;
      clr_cnt     <= '0;
      set_cnt     <= '0;
      coarse      <= '0;
      res_valid   <= 1'b0;
      res_coarse  <= '0;
      res_fine    <= '0;
      res_timeout <= 1'b0;
      res_last    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            remaining <= cmd_samples;
            clr_cnt   <= '0;
            state     <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (clr_cnt == CLR_W'(CLR_CYCLES - 1))
            state <= S_WAIT;
          else
            clr_cnt <= clr_cnt + CLR_W'(1);
        end
        S_WAIT: begin
          coarse <= '0;
          if (start_pulse)
            state <= S_RUN;
        end
        S_RUN: begin
          coarse <= coarse_inc;
          // a hit on the limit edge still counts as a real hit
          if (hit) begin
            res_coarse  <= coarse_inc;
            res_timeout <= 1'b0;
            set_cnt     <= '0;
            state       <= S_SETTLE;
          end else if (at_limit) begin
            res_coarse  <= coarse_inc;
            res_timeout <= 1'b1;
            res_fine    <= '0;
            res_last    <= (remaining == 4'd0);
            res_valid   <= 1'b1;
            state       <= S_REPORT;
          end
        end
        S_SETTLE: begin
          if (set_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
            res_fine  <= popcount(tdc_stages);
            res_last  <= (remaining == 4'd0);
            res_valid <= 1'b1;
            state     <= S_REPORT;
          end else begin
            set_cnt <= set_cnt + SET_W'(1);
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (remaining == 4'd0) begin
              state <= S_IDLE;
            end else begin
              remaining <= remaining - 4'd1;
              clr_cnt   <= '0;
              state     <= S_CLEAR;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Bench for tdc_meas_ctrl: randomized samples checked against
// a cycle-count model of clear, coarse, settle and timeout.
module tb_tdc_meas_ctrl;

  localparam int NS  = 10;
  localparam int CW  = 16;
  localparam int SET = 2;
  localparam int CLR = 10;
  localparam int TO  = 1000;
  localparam int FW  = $clog2(NS + 1);

  typedef logic [5:0][31:0] rv_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [3:0]    cmd_samples = '0;
  logic          start_pulse = 1'b0;
  logic          hit = 1'b0;
  logic          tdc_clr;
  logic [NS-1:0] tdc_stages = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [CW-1:0] res_coarse;
  logic [FW-1:0] res_fine;
  logic          res_timeout;
  logic          res_last;
  logic          busy;

  int total = 0;
  int bad   = 0;

  string fname [6] = '{"coarse", "fine", "timeout",
                       "last", "latency", "clr_len"};

  tdc_meas_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_samples (cmd_samples),
    .start_pulse (start_pulse),
    .hit         (hit),
    .tdc_clr     (tdc_clr),
    .tdc_stages  (tdc_stages),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_coarse  (res_coarse),
    .res_fine    (res_fine),
    .res_timeout (res_timeout),
    .res_last    (res_last),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // d = hit delay in edges after start (0: never hit)
  function automatic rv_t model(int d, logic [NS-1:0] stg,
                                int idx, int n);
    rv_t r;
    r = '0;
    r[5] = CLR;
    r[3] = 32'(idx == n - 1);
    if (d < 1 || d > TO) begin
      r[0] = TO;
      r[2] = 1;
      r[4] = TO;
    end else begin
      r[0] = d;
      r[1] = $countones(stg);
      r[4] = SET;
    end
    return r;
  endfunction

  task automatic issue(input int n);
    cmd_samples = 4'(n - 1);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic ack();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic do_sample(input int d, input logic [NS-1:0] stg,
                           input bit both, output rv_t got);
    int n;
    got = '0;
    n = 0;
    while (!tdc_clr && n < 100) begin tick(); n++; end
    n = 0;
    while (tdc_clr && n < 100) begin tick(); n++; end
    got[5] = n;
    tdc_stages = stg;
    start_pulse = 1'b1;
    hit = both;
    tick();
    start_pulse = 1'b0;
    hit = 1'b0;
    if (d > 0) begin
      repeat (d - 1) tick();
      hit = 1'b1;
      tick();
      hit = 1'b0;
    end
    n = 0;
    while (!res_valid && n < 3 * TO) begin tick(); n++; end
    got[4] = n;
    got[0] = 32'(res_coarse);
    got[1] = 32'(res_fine);
    got[2] = 32'(res_timeout);
    got[3] = 32'(res_last);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if (tdc_clr !== 1'b1) begin
      bad++;
      $display("FAIL reset.tdc_clr: got %b want 1", tdc_clr);
    end
    reset = 1'b0;
    #1;
    total++;
    if ({res_valid, res_timeout, res_last, busy, cmd_ready}
        !== 5'b00001) begin
      bad++;
      $display("FAIL reset.flags: got %b want 00001",
               {res_valid, res_timeout, res_last, busy, cmd_ready});
    end
    total++;
    if (res_coarse !== '0) begin
      bad++;
      $display("FAIL reset.coarse: got %0d want 0", res_coarse);
    end
    total++;
    if (res_fine !== '0) begin
      bad++;
      $display("FAIL reset.fine: got %0d want 0", res_fine);
    end
    total++;
    if (tdc_clr !== 1'b0) begin
      bad++;
      $display("FAIL reset.clr_idle: got %b want 0", tdc_clr);
    end
  endtask

  task automatic test_single();
    rv_t got, exp;
    logic [NS-1:0] stg;
    stg = 10'b0000011111;
    issue(1);
    do_sample(5, stg, 1'b0, got);
    exp = model(5, stg, 0, 1);
    for (int k = 0; k < 6; k++) begin
      total++;
      if (got[k] !== exp[k]) begin
        bad++;
        $display("FAIL single.%s: got %0d want %0d",
                 fname[k], got[k], exp[k]);
      end
    end
    ack();
    total++;
    if ({cmd_ready, busy, res_valid} !== 3'b100) begin
      bad++;
      $display("FAIL single.idle: got %b want 100",
               {cmd_ready, busy, res_valid});
    end
  endtask

  task automatic test_timeout();
    rv_t got, exp;
    logic [NS-1:0] stg;
    int ds [2] = '{0, TO};
    for (int v = 0; v < 2; v++) begin
      stg = NS'($urandom);
      issue(1);
      do_sample(ds[v], stg, 1'b0, got);
      exp = model(ds[v], stg, 0, 1);
      for (int k = 0; k < 6; k++) begin
        total++;
        if (got[k] !== exp[k]) begin
          bad++;
          $display("FAIL timeout%0d.%s: got %0d want %0d",
                   v, fname[k], got[k], exp[k]);
        end
      end
      ack();
    end
  endtask

  task automatic test_multi();
    rv_t got, exp;
    logic [NS-1:0] stg;
    int ds [3] = '{3, 7, 12};
    issue(3);
    for (int i = 0; i < 3; i++) begin
      stg = NS'($urandom);
      do_sample(ds[i], stg, 1'b0, got);
      exp = model(ds[i], stg, i, 3);
      for (int k = 0; k < 6; k++) begin
        total++;
        if (got[k] !== exp[k]) begin
          bad++;
          $display("FAIL multi%0d.%s: got %0d want %0d",
                   i, fname[k], got[k], exp[k]);
        end
      end
      ack();
      total++;
      if ({res_valid, cmd_ready} !== {1'b0, i == 2}) begin
        bad++;
        $display("FAIL multi%0d.after_ack: got %b want %b",
                 i, {res_valid, cmd_ready}, {1'b0, i == 2});
      end
    end
  endtask

  task automatic test_backpressure();
    rv_t got, exp;
    logic [NS-1:0] stg;
    logic [CW+FW+2:0] want, seen;
    stg = NS'($urandom);
    issue(1);
    do_sample(9, stg, 1'b0, got);
    exp = model(9, stg, 0, 1);
    for (int k = 0; k < 6; k++) begin
      total++;
      if (got[k] !== exp[k]) begin
        bad++;
        $display("FAIL bp.%s: got %0d want %0d",
                 fname[k], got[k], exp[k]);
      end
    end
    want = {CW'(exp[0]), FW'(exp[1]), exp[2][0],
            exp[3][0], 1'b1};
    cmd_valid = 1'b1;
    cmd_samples = 4'd5;
    for (int c = 0; c < 20; c++) begin
      start_pulse = 1'($urandom);
      hit = 1'($urandom);
      tdc_stages = NS'($urandom);
      tick();
      seen = {res_coarse, res_fine, res_timeout,
              res_last, res_valid};
      total++;
      if (seen !== want || cmd_ready !== 1'b0
          || tdc_clr !== 1'b0) begin
        bad++;
        $display("FAIL bp.hold%0d: got %h/%b/%b want %h/0/0",
                 c, seen, cmd_ready, tdc_clr, want);
      end
    end
    cmd_valid = 1'b0;
    start_pulse = 1'b0;
    hit = 1'b0;
    ack();
    total++;
    if ({cmd_ready, busy, res_valid} !== 3'b100) begin
      bad++;
      $display("FAIL bp.idle: got %b want 100",
               {cmd_ready, busy, res_valid});
    end
  endtask

  task automatic test_reset_mid_run();
    rv_t got, exp;
    logic [NS-1:0] stg;
    int n;
    stg = NS'($urandom);
    issue(4);
    do_sample(6, stg, 1'b0, got);
    ack();
    n = 0;
    while (tdc_clr && n < 100) begin tick(); n++; end
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    #1;
    total++;
    if (tdc_clr !== 1'b1) begin
      bad++;
      $display("FAIL rst_run.tdc_clr: got %b want 1", tdc_clr);
    end
    tick();
    reset = 1'b0;
    #1;
    total++;
    if ({res_valid, res_timeout, res_last, busy, cmd_ready}
        !== 5'b00001 || res_coarse !== '0 || res_fine !== '0)
    begin
      bad++;
      $display("FAIL rst_run.outs: got %b/%0d/%0d want 00001/0/0",
               {res_valid, res_timeout, res_last, busy, cmd_ready},
               res_coarse, res_fine);
    end
    stg = NS'($urandom);
    issue(1);
    do_sample(11, stg, 1'b0, got);
    exp = model(11, stg, 0, 1);
    for (int k = 0; k < 6; k++) begin
      total++;
      if (got[k] !== exp[k]) begin
        bad++;
        $display("FAIL rst_run.%s: got %0d want %0d",
                 fname[k], got[k], exp[k]);
      end
    end
    ack();
  endtask

  task automatic test_coincide();
    rv_t got, exp;
    logic [NS-1:0] stg;
    stg = 10'b0001101111;
    issue(1);
    do_sample(4, stg, 1'b1, got);
    exp = model(4, stg, 0, 1);
    for (int k = 0; k < 6; k++) begin
      total++;
      if (got[k] !== exp[k]) begin
        bad++;
        $display("FAIL coincide.%s: got %0d want %0d",
                 fname[k], got[k], exp[k]);
      end
    end
    ack();
  endtask

  task automatic test_random();
    rv_t got, exp;
    logic [NS-1:0] stg;
    int n, d;
    bit both;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 4);
      issue(n);
      for (int i = 0; i < n; i++) begin
        d = $urandom_range(1, 40);
        stg = NS'($urandom);
        both = 1'($urandom_range(0, 1));
        do_sample(d, stg, both, got);
        exp = model(d, stg, i, n);
        for (int k = 0; k < 6; k++) begin
          total++;
          if (got[k] !== exp[k]) begin
            bad++;
            $display("FAIL rand%0d_%0d.%s: got %0d want %0d",
                     r, i, fname[k], got[k], exp[k]);
          end
        end
        repeat ($urandom_range(0, 3)) tick();
        ack();
      end
      total++;
      if (cmd_ready !== 1'b1) begin
        bad++;
        $display("FAIL rand%0d.idle: got %b want 1", r, cmd_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_timeout();
    test_multi();
    test_backpressure();
    test_reset_mid_run();
    test_coincide();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
